// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline with a data-bus wait watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no outstanding bus wait; hazards resolved by priority
// MEM_WAIT | MEM access waiting on mem_ack; wait_cnt counts wait cycles
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        cpu_clk,
   input  logic        cpu_rstn,
   input  logic        data_hazard,
   input  logic        EX_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ack,
   output logic        pc_stall,
   output logic        IF_ID_stall,
   output logic        IF_ID_flush,
   output logic        ID_EX_stall,
   output logic        ID_EX_flush,
   output logic        EX_MEM_stall,
   output logic        MEM_WB_flush,
   output logic        bus_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam logic RUN      = 1'b0;
   localparam logic MEM_WAIT = 1'b1;

   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   logic        state_q;
   logic        state_d;
   logic [15:0] wait_cnt_q;
   logic [15:0] wait_cnt_d;
   logic        abort;
   logic        freeze;
   logic        timeout_err;

   always_comb begin
      abort       = (state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT_C);
      freeze      = mem_req & ~mem_ack & ~abort;
      // an ack landing on the abort cycle completes the access, so no error
      timeout_err = abort & mem_req & ~mem_ack;
   end

   always_comb begin
      pc_stall     = 1'b0;
      IF_ID_stall  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_stall  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_stall = 1'b0;
      MEM_WB_flush = 1'b0;
      bus_err      = 1'b0;
      if (cpu_rstn) begin
         if (freeze) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
         end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
         end else if (data_hazard) begin
            pc_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
         end
         if (timeout_err) begin
            MEM_WB_flush = 1'b1;
            bus_err      = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            if (mem_req & ~mem_ack) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 16'd1;
            end
         end
         MEM_WAIT: begin
            // dropped mem_req is a protocol violation: quietly return to RUN
            if (mem_ack | abort | ~mem_req) begin
               state_d    = RUN;
               wait_cnt_d = 16'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 16'd0;
         end
      endcase
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q    <= RUN;
         wait_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic branch_flush;

   always_comb begin
      branch_flush = cpu_rstn & EX_branch_taken & ~freeze;
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (pc_stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (branch_flush) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`else
   // counters absent in this build; control path is unchanged
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It takes the load-use hazard flag from the ID-stage forwarding unit, the branch/jump redirect from EX, and the data-bus handshake from MEM, and drives the per-register stall and flush controls. Those controls are `pc`, `IF/ID`, `ID/EX`, `EX/MEM` and `MEM/WB`. A watchdog bounds data-bus waits.

## Interface
- `TIMEOUT`, default 255: maximum number of wait cycles for `mem_ack` before abort. Range 1..65535.
- `cpu_clk` in 1: clock, rising edge.
- `cpu_rstn` in 1: reset, asynchronous, active-low.
- `data_hazard` in 1: load-use hazard from the ID forwarding unit.
- `EX_branch_taken` in 1: EX resolved a taken branch or jump. Held stable while EX is frozen.
- `mem_req` in 1: MEM-stage load/store needs the data bus. Held until ack or abort.
- `mem_ack` in 1: data bus completes the MEM-stage access this cycle.
- `pc_stall` out 1: hold PC.
- `IF_ID_stall` out 1: hold the IF/ID register.
- `IF_ID_flush` out 1: load a bubble into IF/ID.
- `ID_EX_stall` out 1: hold the ID/EX register.
- `ID_EX_flush` out 1: load a bubble into ID/EX.
- `EX_MEM_stall` out 1: hold the EX/MEM register.
- `MEM_WB_flush` out 1: load a bubble into MEM/WB.
- `bus_err` out 1: one-cycle pulse when a bus wait times out.
- `perf_stall_cnt` out 32: cycles with `pc_stall`=1. Present only with `HAZARD_PERF_CNT_EN`.
- `perf_flush_cnt` out 32: cycles with `EX_branch_taken` flush applied. Present only with `HAZARD_PERF_CNT_EN`.

## Operation
- States: `RUN`, `MEM_WAIT`. Internal `wait_cnt` is 16 bits.
- `freeze` = (`mem_req` & ~`mem_ack`) & ~abort. Abort = state `MEM_WAIT` & `wait_cnt`==`TIMEOUT`.
- Priority, highest first:
  1. `freeze`: `pc_stall`, `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_stall` all 1. `MEM_WB_flush`=1. All other flushes 0. Branch and load-use are ignored this cycle.
  2. `EX_branch_taken`: `IF_ID_flush`=1, `ID_EX_flush`=1. No stalls. A concurrent `data_hazard` is ignored because the ID instruction is wrong-path.
  3. `data_hazard`: `pc_stall`=1, `IF_ID_stall`=1, `ID_EX_flush`=1. Everything else 0.
  4. Otherwise all outputs are 0.
- All stall/flush outputs are combinational from state and inputs, with no register delay.
- Transitions:
  - `RUN`→`MEM_WAIT` when `mem_req` & ~`mem_ack`; `wait_cnt` is set to 1.
  - `MEM_WAIT`→`RUN` when `mem_ack`, or on abort; `wait_cnt` is set to 0.
  - In `MEM_WAIT` otherwise, `wait_cnt` increments by 1.
- Abort cycle:
  - The pipeline is released (no freeze). `bus_err`=1 for exactly that cycle and is registered-free, i.e. combinational from state plus `wait_cnt`.
  - The MEM/WB bubble is still inserted: `MEM_WB_flush`=1 on the abort cycle, so the faulting access never writes back.
- `mem_ack` arriving in the same cycle as `mem_req` causes zero stall cycles and no state change.
- `mem_ack` without `mem_req` is ignored.
- `mem_req` dropping in `MEM_WAIT` without ack is a protocol violation. The FSM returns to `RUN` and no `bus_err` is raised.

## Timing
- Reset (`cpu_rstn`=0, asynchronous):
  - State is `RUN` and `wait_cnt` is 0.
  - Counters are 0.
  - All outputs are 0 regardless of inputs. Stall/flush outputs are gated by reset so that no stale hazard propagates.
- Reset asserted mid-`MEM_WAIT`: return to `RUN` immediately. No `bus_err` is raised.
- Load-use costs exactly 1 stall cycle. The forwarding unit deasserts `data_hazard` once the load reaches MEM.
- Taken branch costs 2 bubbles (IF/ID and ID/EX) in one cycle.
- A bus wait of N cycles without ack gives N freeze cycles, where N ≤ `TIMEOUT`. At `wait_cnt`==`TIMEOUT` the next cycle is the abort cycle. The total maximum freeze is therefore `TIMEOUT` cycles.
- Branch arriving during freeze: EX is held, so the flush is applied in the first non-freeze cycle.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `perf_stall_cnt` and `perf_flush_cnt` exist as ports.
  - They increment on rising edges when the respective condition holds, and wrap from 0xFFFFFFFF to 0.
  - They reset to 0.
- `HAZARD_PERF_CNT_EN` undefined: both ports and their registers are absent. Control behaviour is identical.

## Test plan
- Load-use: `data_hazard`=1 for one cycle → `pc_stall`=`IF_ID_stall`=`ID_EX_flush`=1 for exactly that cycle. `perf_stall_cnt` goes 0→1.
- Branch with load-use: `EX_branch_taken`=1 and `data_hazard`=1 together → `IF_ID_flush`=`ID_EX_flush`=1, `pc_stall`=0.
- Bus wait: `mem_req` high, `mem_ack` arriving after 3 cycles → 3 freeze cycles with `MEM_WB_flush`=1. Release on the ack cycle with all outputs 0. FSM back to `RUN`.
- Timeout with `TIMEOUT`=4: `mem_req` high and no ack → 4 freeze cycles. Then one cycle with `bus_err`=1, stalls 0 and `MEM_WB_flush`=1. Then `RUN`.
- Reset mid-wait: `cpu_rstn` pulled low in cycle 2 of `MEM_WAIT` → all outputs 0 immediately and `bus_err` never asserted. After release, `mem_ack` with `mem_req` gives no stall.
- Counter wrap (`HAZARD_PERF_CNT_EN` defined): force `perf_flush_cnt`=0xFFFFFFFF, then apply one branch flush → count becomes 0x00000000.
